lm_sm_sequencer: RTL and testbench
==================================

// Module: lm_sm_sequencer
// PURPOSE
//  Decode-stage expander for LM/SM. Turns one LM/SM instruction from IF/ID into one micro-op per
//  set bit of its 8-bit register list. Each micro-op is presented to the ID/RR pipeline register
//  (is_lm/is_sm, rd_addr_1/2, wr_add, reg_write, mem_rd/mem_write, addr_offset).
//  Holds PC and IF/ID via stall_fetch until the final micro-op issues.
// PARAMETERS
//  OP_LM    4'b0110  opcode of load-multiple
//  OP_SM    4'b0111  opcode of store-multiple
//  OFF_W    16       width of addr_offset_out
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   asynchronous, active-low reset
//  instr_in         in   16  IF/ID instruction; [15:12] opcode, [11:9] RA base, [7:0] reg list
//  valid_in         in   1   instr_in holds a live instruction (not a bubble)
//  id_stall_in      in   1   hazard stall on ID/RR; freeze sequencer
//  flush_in         in   1   branch/jump flush; abandon any sequence in progress
//  uop_valid_out    out  1   a LM/SM micro-op is presented this cycle
//  is_lm_out        out  1   micro-op belongs to LM
//  is_sm_out        out  1   micro-op belongs to SM
//  rd_addr_1_out    out  3   base register RA, constant across the sequence
//  rd_addr_2_out    out  3   SM: data register to store; LM: 0
//  wr_add_out       out  3   LM: destination register; SM: 0
//  reg_write_out    out  1   = is_lm_out
//  mem_rd_out       out  1   = is_lm_out
//  mem_write_out    out  1   = is_sm_out
//  addr_offset_out  out  16  zero-extended index of this micro-op within the sequence (0,1,2..)
//  last_out         out  1   this micro-op is the final one of the sequence
//  stall_fetch      out  1   hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset (rst low, async): state=IDLE, mask=0, count=0, op/base regs=0; every output forced 0
//    while rst is low.
//  - Outputs are combinational from state + instr_in (IDLE) or captured regs (SEQ). ID/RR
//    registers them, so the first micro-op has zero added latency.
//  - Register list order: ascending, bit k -> Rk; lowest set bit issues first.
//  - IDLE, lmsm = valid_in & (opcode==OP_LM | opcode==OP_SM) & !flush_in:
//      list==0   -> no micro-op; uop_valid_out=0, stall_fetch=0; instruction consumed as bubble.
//      list!=0   -> emit micro-op for lowest set bit, offset 0; last_out=(popcount==1).
//      popcount>1 -> stall_fetch=1. If !id_stall_in: capture op, RA, mask=list minus that bit,
//                    count=1, go to SEQ.
//    A non-LM/SM or invalid instruction: all outputs 0, stay IDLE.
//  - SEQ: emit micro-op for lowest set bit of mask, addr_offset_out=count.
//      last_out=(popcount(mask)==1); stall_fetch=!last_out.
//      If !id_stall_in: clear that bit, count+1. When last issues, go to IDLE; on that cycle
//      IF/ID advances.
//  - id_stall_in=1: no state change; outputs stay stable. stall_fetch keeps its computed value.
//  - flush_in=1: uop_valid_out=0 and all outputs 0 this cycle; next state IDLE, mask/count cleared.
//    flush_in has priority over id_stall_in.
//  - count saturates naturally at 8 (max list 8'hFF); it never wraps.
//  - RA appearing in an LM list is loaded like any other register; no special case.
// TESTING
//  1. LM R2, list 8'b1010_0001 -> 3 cycles:
//     wr_add 0,5,7; offset 0,1,2; rd_addr_1=2; stall_fetch 1,1,0; last 0,0,1; reg_write=mem_rd=1.
//  2. SM R4, list 8'h80 -> 1 cycle: rd_addr_2=7, mem_write=1, wr_add=0, last=1, stall_fetch=0;
//     next instr decodes the following cycle.
//  3. LM list 8'h00 -> uop_valid 0, stall_fetch 0, state stays IDLE.
//  4. SM list 8'h0F, id_stall_in high 2 cycles at offset 1 -> rd_addr_2=1/offset=1 held 3 cycles;
//     then offsets 2,3 issue.
//  5. LM list 8'hFF, flush_in at offset 3 -> outputs 0 that cycle; IDLE next cycle; no further
//     micro-ops.
//  6. rst low mid-sequence (offset 2 of 8'hFF) -> outputs 0 immediately.
//     After release, LM list 8'hFF yields 8 micro-ops, wr_add 0..7, offset 0..7, stall_fetch low
//     only on the eighth.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
// Handshake bundle between the IF/ID stage and the LM/SM micro-op sequencer.
// The sequencer side (slave) consumes the instruction and drives the micro-op fields.
interface lm_sm_sequencer_if #(
    parameter int OFF_W = 16
);
    logic [15:0]      instr_in;
    logic             valid_in;
    logic             id_stall_in;
    logic             flush_in;
    logic             uop_valid_out;
    logic             is_lm_out;
    logic             is_sm_out;
    logic [2:0]       rd_addr_1_out;
    logic [2:0]       rd_addr_2_out;
    logic [2:0]       wr_add_out;
    logic             reg_write_out;
    logic             mem_rd_out;
    logic             mem_write_out;
    logic [OFF_W-1:0] addr_offset_out;
    logic             last_out;
    logic             stall_fetch;

    modport master (
        output instr_in, valid_in, id_stall_in, flush_in,
        input  uop_valid_out, is_lm_out, is_sm_out, rd_addr_1_out, rd_addr_2_out,
               wr_add_out, reg_write_out, mem_rd_out, mem_write_out,
               addr_offset_out, last_out, stall_fetch
    );

    modport slave (
        input  instr_in, valid_in, id_stall_in, flush_in,
        output uop_valid_out, is_lm_out, is_sm_out, rd_addr_1_out, rd_addr_2_out,
               wr_add_out, reg_write_out, mem_rd_out, mem_write_out,
               addr_offset_out, last_out, stall_fetch
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Decode-stage expander: one LM/SM instruction becomes one micro-op per set bit of its
// register list, lowest register first, with fetch held until the final micro-op issues.
module lm_sm_sequencer #(
    parameter logic [3:0] OP_LM = 4'b0110,
    parameter logic [3:0] OP_SM = 4'b0111,
    parameter int         OFF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    lm_sm_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, SEQ} state_t;

    state_t     state;
    logic       is_lm_q;
    logic [2:0] base_q;
    logic [7:0] mask_q;
    logic [3:0] count_q;

    logic [3:0] opcode;
    logic [7:0] cur_mask;
    logic [7:0] rest_mask;
    logic [3:0] cur_count;
    logic [2:0] cur_base;
    logic [2:0] cur_reg;
    logic       cur_lm;
    logic       active;
    logic       last;
    logic       unused_bit;

    function automatic logic [2:0] low_idx(input logic [7:0] m);
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) low_idx = 3'(i);
        end
    endfunction

    assign opcode     = bus.instr_in[15:12];
    assign unused_bit = bus.instr_in[8];

    // In IDLE the live instruction is decoded directly so the first micro-op costs no cycle.
    always_comb begin
        cur_mask  = 8'd0;
        cur_count = 4'd0;
        cur_base  = 3'd0;
        cur_lm    = 1'b0;
        if (state == IDLE) begin
            cur_lm   = (opcode == OP_LM);
            cur_base = bus.instr_in[11:9];
            if (bus.valid_in && !bus.flush_in && ((opcode == OP_LM) || (opcode == OP_SM)))
                cur_mask = bus.instr_in[7:0];
        end else begin
            cur_lm    = is_lm_q;
            cur_base  = base_q;
            cur_count = count_q;
            if (!bus.flush_in)
                cur_mask = mask_q;
        end
    end

    assign rest_mask = cur_mask & (cur_mask - 8'd1);
    assign last      = (rest_mask == 8'd0);
    assign active    = rst && (cur_mask != 8'd0);
    assign cur_reg   = low_idx(cur_mask);

    always_comb begin
        bus.uop_valid_out   = active;
        bus.is_lm_out       = active && cur_lm;
        bus.is_sm_out       = active && !cur_lm;
        bus.rd_addr_1_out   = active ? cur_base : 3'd0;
        bus.rd_addr_2_out   = (active && !cur_lm) ? cur_reg : 3'd0;
        bus.wr_add_out      = (active && cur_lm) ? cur_reg : 3'd0;
        bus.reg_write_out   = active && cur_lm;
        bus.mem_rd_out      = active && cur_lm;
        bus.mem_write_out   = active && !cur_lm;
        bus.addr_offset_out = active ? OFF_W'(cur_count) : '0;
        bus.last_out        = active && last;
        bus.stall_fetch     = active && !last;
    end

    // Sequence state advances only when ID/RR accepts the micro-op; flush overrides a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            is_lm_q <= 1'b0;
            base_q  <= 3'd0;
            mask_q  <= 8'd0;
            count_q <= 4'd0;
        end else if (bus.flush_in) begin
            state   <= IDLE;
            mask_q  <= 8'd0;
            count_q <= 4'd0;
        end else if (!bus.id_stall_in && active) begin
            if (state == IDLE) begin
                if (!last) begin
                    state   <= SEQ;
                    is_lm_q <= cur_lm;
                    base_q  <= cur_base;
                    mask_q  <= rest_mask;
                    count_q <= 4'd1;
                end
            end else begin
                mask_q  <= rest_mask;
                count_q <= count_q + 4'd1;
                if (last) begin
                    state   <= IDLE;
                    count_q <= 4'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for the LM/SM sequencer: each vector's micro-op fields are hand-derived
// from the register list and compared every cycle.
module tb_lm_sm_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lm_sm_sequencer_if #(.OFF_W(16)) bus ();

    lm_sm_sequencer #(
        .OP_LM (4'b0110),
        .OP_SM (4'b0111),
        .OFF_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [3:0] LM = 4'b0110;
    localparam logic [3:0] SM = 4'b0111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] ra,
                                       input logic [7:0] list);
        return {op, ra, 1'b0, list};
    endfunction

    task automatic drive(input logic [15:0] instr, input logic v, input logic st,
                         input logic fl);
        @(negedge clk);
        bus.instr_in    = instr;
        bus.valid_in    = v;
        bus.id_stall_in = st;
        bus.flush_in    = fl;
        #1;
    endtask

    task automatic chk_uop(input string tag, input logic lm, input logic [2:0] ra,
                           input logic [2:0] r, input logic [3:0] off, input logic last);
        check({tag, ".valid"}, 32'(bus.uop_valid_out), 32'd1);
        check({tag, ".is_lm"}, 32'(bus.is_lm_out), 32'(lm));
        check({tag, ".is_sm"}, 32'(bus.is_sm_out), 32'(!lm));
        check({tag, ".rd1"}, 32'(bus.rd_addr_1_out), 32'(ra));
        check({tag, ".rd2"}, 32'(bus.rd_addr_2_out), lm ? 32'd0 : 32'(r));
        check({tag, ".wr"}, 32'(bus.wr_add_out), lm ? 32'(r) : 32'd0);
        check({tag, ".reg_write"}, 32'(bus.reg_write_out), 32'(lm));
        check({tag, ".mem_rd"}, 32'(bus.mem_rd_out), 32'(lm));
        check({tag, ".mem_write"}, 32'(bus.mem_write_out), 32'(!lm));
        check({tag, ".offset"}, 32'(bus.addr_offset_out), 32'(off));
        check({tag, ".last"}, 32'(bus.last_out), 32'(last));
        check({tag, ".stall_fetch"}, 32'(bus.stall_fetch), 32'(!last));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".valid"}, 32'(bus.uop_valid_out), 32'd0);
        check({tag, ".stall_fetch"}, 32'(bus.stall_fetch), 32'd0);
        check({tag, ".is_lm"}, 32'(bus.is_lm_out), 32'd0);
        check({tag, ".is_sm"}, 32'(bus.is_sm_out), 32'd0);
        check({tag, ".rd1"}, 32'(bus.rd_addr_1_out), 32'd0);
        check({tag, ".wr"}, 32'(bus.wr_add_out), 32'd0);
        check({tag, ".mem_write"}, 32'(bus.mem_write_out), 32'd0);
        check({tag, ".offset"}, 32'(bus.addr_offset_out), 32'd0);
        check({tag, ".last"}, 32'(bus.last_out), 32'd0);
    endtask

    initial begin
        // Reset with a live LM presented: everything must stay 0.
        rst             = 1'b0;
        bus.instr_in    = mk(LM, 3'd3, 8'hFF);
        bus.valid_in    = 1'b1;
        bus.id_stall_in = 1'b0;
        bus.flush_in    = 1'b0;
        #1;
        chk_idle("rst");
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk_idle("rst2");
        rst = 1'b1;

        // 1: LM R2, list 1010_0001 -> R0, R5, R7
        drive(mk(LM, 3'd2, 8'b1010_0001), 1'b1, 1'b0, 1'b0);
        chk_uop("t1.u0", 1'b1, 3'd2, 3'd0, 4'd0, 1'b0);
        drive(mk(LM, 3'd2, 8'b1010_0001), 1'b1, 1'b0, 1'b0);
        chk_uop("t1.u1", 1'b1, 3'd2, 3'd5, 4'd1, 1'b0);
        drive(mk(LM, 3'd2, 8'b1010_0001), 1'b1, 1'b0, 1'b0);
        chk_uop("t1.u2", 1'b1, 3'd2, 3'd7, 4'd2, 1'b1);

        // 2: SM R4, list 80 -> single micro-op, then next instruction decodes immediately
        drive(mk(SM, 3'd4, 8'h80), 1'b1, 1'b0, 1'b0);
        chk_uop("t2.u0", 1'b0, 3'd4, 3'd7, 4'd0, 1'b1);
        drive(mk(4'h1, 3'd1, 8'h34), 1'b1, 1'b0, 1'b0);
        chk_idle("t2.next");

        // 3: LM with empty list is a bubble
        drive(mk(LM, 3'd5, 8'h00), 1'b1, 1'b0, 1'b0);
        chk_idle("t3.empty");
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk_idle("t3.after");

        // 4: SM R1, list 0F, id stall held 2 cycles at offset 1
        drive(mk(SM, 3'd1, 8'h0F), 1'b1, 1'b0, 1'b0);
        chk_uop("t4.u0", 1'b0, 3'd1, 3'd0, 4'd0, 1'b0);
        drive(mk(SM, 3'd1, 8'h0F), 1'b1, 1'b1, 1'b0);
        chk_uop("t4.u1a", 1'b0, 3'd1, 3'd1, 4'd1, 1'b0);
        drive(mk(SM, 3'd1, 8'h0F), 1'b1, 1'b1, 1'b0);
        chk_uop("t4.u1b", 1'b0, 3'd1, 3'd1, 4'd1, 1'b0);
        drive(mk(SM, 3'd1, 8'h0F), 1'b1, 1'b0, 1'b0);
        chk_uop("t4.u1c", 1'b0, 3'd1, 3'd1, 4'd1, 1'b0);
        drive(mk(SM, 3'd1, 8'h0F), 1'b1, 1'b0, 1'b0);
        chk_uop("t4.u2", 1'b0, 3'd1, 3'd2, 4'd2, 1'b0);
        drive(mk(SM, 3'd1, 8'h0F), 1'b1, 1'b0, 1'b0);
        chk_uop("t4.u3", 1'b0, 3'd1, 3'd3, 4'd3, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk_idle("t4.after");

        // 5: LM R3, list FF, flush at offset 3 (stall also high: flush wins)
        for (int k = 0; k < 3; k++) begin
            drive(mk(LM, 3'd3, 8'hFF), 1'b1, 1'b0, 1'b0);
            chk_uop($sformatf("t5.u%0d", k), 1'b1, 3'd3, 3'(k), 4'(k), 1'b0);
        end
        drive(mk(LM, 3'd3, 8'hFF), 1'b1, 1'b1, 1'b1);
        chk_idle("t5.flush");
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk_idle("t5.post1");
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk_idle("t5.post2");

        // 6: reset mid-sequence, then a full 8-register LM
        for (int k = 0; k < 3; k++) begin
            drive(mk(LM, 3'd0, 8'hFF), 1'b1, 1'b0, 1'b0);
            chk_uop($sformatf("t6a.u%0d", k), 1'b1, 3'd0, 3'(k), 4'(k), 1'b0);
        end
        rst = 1'b0;
        #1;
        chk_idle("t6.rst");
        drive(mk(LM, 3'd6, 8'hFF), 1'b1, 1'b0, 1'b0);
        chk_idle("t6.rst_hold");
        rst = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) drive(mk(LM, 3'd6, 8'hFF), 1'b1, 1'b0, 1'b0);
            chk_uop($sformatf("t6b.u%0d", k), 1'b1, 3'd6, 3'(k), 4'(k), k == 7);
        end
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk_idle("t6.after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
